// File: rtl/charbuf_writer_if.sv
// Character/attribute stream into the character-buffer writer, valid/ready handshake.
interface charbuf_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic [7:0] in_attr;

  modport master (output in_valid, output in_char, output in_attr, input in_ready);
  modport slave  (input in_valid, input in_char, input in_attr, output in_ready);
endinterface

// File: rtl/charbuf_writer.sv
// charbuf_writer: write-port controller for the colour character buffer (cursor, control codes, clears).
// Latency: one cycle from stream handshake to buffer write and cursor update; CHARBUF_SCROLL_EN selects hardware scroll.
// Backpressure: in_ready low during full/line clears and on any cycle with clear_req.
module charbuf_writer #(
  parameter int         COLS       = 64,
  parameter int         ROWS       = 32,
  parameter int         ADDR_W     = 11,
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter logic [7:0] BLANK_ATTR = 8'h07
) (
  input  logic                      clk,
  input  logic                      rst_n,
  charbuf_writer_if.slave           in_if,
  input  logic                      clear_req,
  output logic                      busy,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [15:0]               wr_data,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [$clog2(ROWS)-1:0]   row_base
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(COLS * ROWS);
  localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(COLS);
  localparam logic [15:0] BLANK   = {BLANK_ATTR, BLANK_CHAR};
  localparam logic [7:0]  CODE_BS = 8'h08;
  localparam logic [7:0]  CODE_LF = 8'h0A;
  localparam logic [7:0]  CODE_FF = 8'h0C;
  localparam logic [7:0]  CODE_CR = 8'h0D;

  typedef enum logic [1:0] {IDLE, FCLR, LCLR} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [COL_W-1:0]  col_nxt;
  logic [ROW_W-1:0]  row_nxt, lclr_row, lclr_row_nxt, phys_row;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [15:0]       wr_data_nxt;
  logic              hs, is_cr, is_lf, is_bs, is_ff, printable;
  logic              start_fclr, advance, at_bottom;

  assign in_if.in_ready = (state == IDLE) && !clear_req;
  assign busy           = (state == FCLR);
  assign hs             = in_if.in_valid && in_if.in_ready;

  assign is_cr      = (in_if.in_char == CODE_CR);
  assign is_lf      = (in_if.in_char == CODE_LF);
  assign is_bs      = (in_if.in_char == CODE_BS);
  assign is_ff      = (in_if.in_char == CODE_FF);
  assign printable  = !(is_cr || is_lf || is_bs || is_ff);
  assign start_fclr = clear_req || (hs && is_ff);
  assign at_bottom  = (cursor_row == ROW_W'(ROWS - 1));
  assign advance    = hs && (is_lf || (printable && cursor_col == COL_W'(COLS - 1)));

`ifdef CHARBUF_SCROLL_EN
  logic [ROW_W-1:0] base_q, base_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) base_q <= '0;
    else        base_q <= base_nxt;
  end

  assign row_base = base_q;
  assign phys_row = base_q + cursor_row;
`else
  assign row_base = '0;
  assign phys_row = cursor_row;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_fclr) begin
      state_nxt = FCLR;
    end else begin
      unique case (state)
        IDLE:    if (advance && at_bottom) state_nxt = LCLR;
        FCLR:    if (cnt == FULL_CNT) state_nxt = IDLE;
        LCLR:    if (cnt == LINE_CNT) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    col_nxt      = cursor_col;
    row_nxt      = cursor_row;
    cnt_nxt      = cnt;
    lclr_row_nxt = lclr_row;
`ifdef CHARBUF_SCROLL_EN
    base_nxt     = base_q;
`endif
    if (start_fclr) begin
      wr_en_nxt   = 1'b1;
      wr_addr_nxt = '0;
      wr_data_nxt = BLANK;
      cnt_nxt     = CNT_W'(1);
      col_nxt     = '0;
      row_nxt     = '0;
`ifdef CHARBUF_SCROLL_EN
      base_nxt    = '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (hs) begin
          if (printable) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = {phys_row, cursor_col};
            wr_data_nxt = {in_if.in_attr, in_if.in_char};
            col_nxt     = cursor_col + COL_W'(1);
          end else if (is_cr || is_lf) begin
            col_nxt = '0;
          end else if (is_bs && cursor_col != '0) begin
            col_nxt = cursor_col - COL_W'(1);
          end
          if (advance) begin
            if (!at_bottom) begin
              row_nxt = cursor_row + ROW_W'(1);
            end else begin
`ifdef CHARBUF_SCROLL_EN
              base_nxt     = base_q + ROW_W'(1);
              lclr_row_nxt = base_nxt + row_nxt;
`else
              row_nxt      = '0;
              lclr_row_nxt = '0;
`endif
              // A wrapping printable already owns this cycle's write; the line clear starts next cycle.
              cnt_nxt = '0;
              if (!printable) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = {lclr_row_nxt, {COL_W{1'b0}}};
                wr_data_nxt = BLANK;
                cnt_nxt     = CNT_W'(1);
              end
            end
          end
        end
        FCLR: if (cnt != FULL_CNT) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = cnt[ADDR_W-1:0];
          wr_data_nxt = BLANK;
          cnt_nxt     = cnt + CNT_W'(1);
        end
        LCLR: if (cnt != LINE_CNT) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = {lclr_row, cnt[COL_W-1:0]};
          wr_data_nxt = BLANK;
          cnt_nxt     = cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      cnt        <= '0;
      lclr_row   <= '0;
    end else begin
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      cursor_col <= col_nxt;
      cursor_row <= row_nxt;
      cnt        <= cnt_nxt;
      lclr_row   <= lclr_row_nxt;
    end
  end
endmodule

// File: tb/tb_charbuf_writer.sv
// Scoreboarded bench for charbuf_writer; builds with or without CHARBUF_SCROLL_EN.
module tb_charbuf_writer;
  localparam int COLS = 64;
  localparam int ROWS = 32;
  localparam logic [15:0] BLANK = 16'h0720;
`ifdef CHARBUF_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        busy, wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row, row_base;

  charbuf_writer_if sif ();

  charbuf_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (sif),
    .clear_req  (clear_req),
    .busy       (busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .row_base   (row_base)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [26:0] exp_q[$];
  int m_col = 0, m_row = 0, m_base = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every buffer write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(wr_en), 32'd0);
      else chk("wr", {5'd0, wr_addr, wr_data}, {5'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int addr, input logic [15:0] d);
    exp_q.push_back({11'(addr), d});
  endtask

  task automatic model_full_clear();
    m_col = 0; m_row = 0; m_base = 0;
    for (int i = 0; i < COLS * ROWS; i++) push(i, BLANK);
  endtask

  task automatic model_adv();
    if (m_row < ROWS - 1) m_row++;
    else begin
      if (SCROLL) m_base = (m_base + 1) % ROWS;
      else m_row = 0;
      for (int i = 0; i < COLS; i++) push(((m_base + m_row) % ROWS) * COLS + i, BLANK);
    end
  endtask

  task automatic model(input logic [7:0] c, input logic [7:0] a);
    case (c)
      8'h0D: m_col = 0;
      8'h0A: begin m_col = 0; model_adv(); end
      8'h08: if (m_col > 0) m_col--;
      8'h0C: model_full_clear();
      default: begin
        push(((m_base + m_row) % ROWS) * COLS + m_col, {a, c});
        if (m_col == COLS - 1) begin m_col = 0; model_adv(); end
        else m_col++;
      end
    endcase
  endtask

  // Returns mid-cycle of the cycle after the handshake.
  task automatic hs(input logic [7:0] c, input logic [7:0] a);
    int n;
    n = 0;
    sif.in_valid = 1'b1; sif.in_char = c; sif.in_attr = a;
    while (!sif.in_ready && n < 5000) begin tick(); n++; end
    if (!sif.in_ready) chk("hs_timeout", 32'(sif.in_ready), 32'd1);
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a, output int stall);
    model(c, a);
    hs(c, a);
    chk("col", 32'(cursor_col), 32'(m_col));
    chk("row", 32'(cursor_row), 32'(m_row));
    chk("base", 32'(row_base), 32'(m_base));
    stall = 0;
    while (!sif.in_ready && stall < 5000) begin tick(); stall++; end
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin n++; tick(); end
  endtask

  initial begin
    int n, st;
    sif.in_valid = 1'b0; sif.in_char = 8'h00; sif.in_attr = 8'h00;
    repeat (3) tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_base", 32'(row_base), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(sif.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Full clear from clear_req
    model_full_clear();
    pulse_clear();
    chk("fclr_busy_on", 32'(busy), 32'd1);
    wait_idle(n);
    chk("fclr_len", 32'(n), 32'd2048);
    chk("fclr_ready_after", 32'(sif.in_ready), 32'd1);
    chk("fclr_col", 32'(cursor_col), 32'd0);
    chk("fclr_row", 32'(cursor_row), 32'd0);
    chk("fclr_sb", 32'(exp_q.size()), 32'd0);

    // First printable
    send(8'h41, 8'h1E, st);
    chk("A_wr_en", 32'(wr_en), 32'd1);
    chk("A_addr", 32'(wr_addr), 32'd0);
    chk("A_data", 32'(wr_data), 32'h1E41);
    chk("A_col", 32'(cursor_col), 32'd1);

    // CR at col 10
    for (int i = 0; i < 9; i++) send(8'h61 + 8'(i), 8'h07, st);
    chk("pre_cr_col", 32'(cursor_col), 32'd10);
    send(8'h0D, 8'h00, st);
    chk("cr_no_wr", 32'(wr_en), 32'd0);
    chk("cr_col", 32'(cursor_col), 32'd0);
    chk("cr_stall", 32'(st), 32'd0);

    // LF at row 3
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00, st);
    send(8'h0A, 8'h00, st);
    chk("lf_row", 32'(cursor_row), 32'd4);
    chk("lf_col", 32'(cursor_col), 32'd0);

    // BS at col 0 and col 2
    send(8'h08, 8'h00, st);
    chk("bs0_col", 32'(cursor_col), 32'd0);
    send(8'h31, 8'h17, st);
    send(8'h32, 8'h17, st);
    send(8'h08, 8'h00, st);
    chk("bs2_col", 32'(cursor_col), 32'd1);
    chk("bs_no_wr", 32'(wr_en), 32'd0);

    // Line overflow at row 5
    send(8'h0A, 8'h00, st);
    for (int i = 0; i < 63; i++) send(8'h40 + 8'(i % 26), 8'h03, st);
    send(8'h5A, 8'h0E, st);
    chk("ovf_addr", 32'(wr_addr), 32'd383);
    chk("ovf_data", 32'(wr_data), 32'h0E5A);
    chk("ovf_col", 32'(cursor_col), 32'd0);
    chk("ovf_row", 32'(cursor_row), 32'd6);
    chk("ovf_no_lclr", 32'(st), 32'd0);
    tick();
    chk("ovf_wr_idle", 32'(wr_en), 32'd0);

    // Bottom LF
    for (int i = 0; i < 25; i++) send(8'h0A, 8'h00, st);
    chk("bot_row", 32'(cursor_row), 32'd31);
    send(8'h0A, 8'h00, st);
    chk("bot_stall", 32'(st), 32'd64);
    chk("bot_row_after", 32'(cursor_row), SCROLL ? 32'd31 : 32'd0);
    chk("bot_base_after", 32'(row_base), SCROLL ? 32'd1 : 32'd0);
    send(8'h42, 8'h2F, st);
    chk("B_addr", 32'(wr_addr), 32'd0);
    chk("B_data", 32'(wr_data), 32'h2F42);

    // FF acts as a full clear
    send(8'h0C, 8'h00, st);
    chk("ff_stall", 32'(st), 32'd2048);
    chk("ff_base", 32'(row_base), 32'd0);
    chk("ff_sb", 32'(exp_q.size()), 32'd0);

    // clear_req and in_valid together: character dropped
    model_full_clear();
    sif.in_valid = 1'b1; sif.in_char = 8'h51; sif.in_attr = 8'h4E;
    clear_req = 1'b1;
    #1;
    chk("cv_ready", 32'(sif.in_ready), 32'd0);
    @(posedge clk); #1;
    clear_req = 1'b0; sif.in_valid = 1'b0;
    @(negedge clk); #1;
    chk("cv_busy", 32'(busy), 32'd1);
    chk("cv_addr", 32'(wr_addr), 32'd0);
    wait_idle(n);
    chk("cv_len", 32'(n), 32'd2048);

    // clear_req 20 cycles into a line clear
    for (int i = 0; i < 31; i++) send(8'h0A, 8'h00, st);
    chk("ab_row", 32'(cursor_row), 32'd31);
    for (int i = 0; i <= 20; i++) push(i, BLANK);
    model_full_clear();
    hs(8'h0A, 8'h00);
    chk("ab_lclr_ready", 32'(sif.in_ready), 32'd0);
    repeat (20) tick();
    chk("ab_col20", 32'(wr_addr), 32'd20);
    pulse_clear();
    chk("ab_fclr_addr", 32'(wr_addr), 32'd0);
    chk("ab_busy", 32'(busy), 32'd1);
    wait_idle(n);
    chk("ab_len", 32'(n), 32'd2048);
    chk("ab_col", 32'(cursor_col), 32'd0);
    chk("ab_row_end", 32'(cursor_row), 32'd0);

    repeat (3) tick();
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/charbuf_writer.md
Name: charbuf_writer

Overview:
- Write-side controller for the 64x32 colour character buffer (16-bit words: char in [7:0], attribute in [15:8]); drives the buffer's write port A.
- Accepts a character/attribute stream over a valid/ready handshake and interprets control codes.
- Maintains the cursor, performs full-screen and single-line clears, and handles bottom-of-screen wrap or scroll.
- The VGA text renderer on read port B is the consumer of the buffer contents.

Parameters:
- COLS, 64, characters per row; power of two.
- ROWS, 32, rows per screen; power of two.
- ADDR_W, 11, buffer address width; equals log2(COLS*ROWS).
- BLANK_CHAR, 8'h20, character written by clear operations.
- BLANK_ATTR, 8'h07, attribute written by clear operations.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_char/in_attr valid.
- in_ready  out  1  writer can accept a character this cycle.
- in_char  in  8  character code or control code.
- in_attr  in  8  colour attribute for printable characters.
- clear_req  in  1  single-cycle pulse; clear whole screen.
- busy  out  1  clear sequence in progress.
- wr_en  out  1  to buffer cea; write strobe.
- wr_addr  out  ADDR_W  to buffer ada; {phys_row[4:0], col[5:0]}.
- wr_data  out  16  to buffer din; {attr, char}.
- cursor_col  out  6  current cursor column.
- cursor_row  out  5  current logical cursor row.
- row_base  out  5  physical row shown at top of screen; constant 0 without the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - wr_en=0, wr_addr=0, wr_data=0, cursor 0/0, row_base=0, state IDLE, busy=0.
  - Buffer contents are not cleared by reset.
- States:
  - IDLE: accept characters.
  - FCLR: full clear, COLS*ROWS cycles.
  - LCLR: line clear, COLS cycles.
- in_ready = (state==IDLE) && !clear_req. busy = (state==FCLR).
- Outputs are registered. A handshake at cycle N produces its buffer write (wr_en/wr_addr/wr_data) at cycle N+1 and cursor update visible at N+1.
- Physical row = (row_base + cursor_row) mod ROWS.
- Code handling in IDLE, on handshake:
  - 0x0D CR: col=0; no write.
  - 0x0A LF: col=0, row advance (see below); no write.
  - 0x08 BS: if col>0 then col-1, else no change; no write.
  - 0x0C FF: same as clear_req.
  - Any other code: write {in_attr,in_char} at cursor, then col+1. If col was COLS-1, col=0 and row advance.
- Row advance:
  - If cursor_row<ROWS-1: cursor_row+1, no clear.
  - Else (bottom): wrap/scroll per optional feature, then enter LCLR for the new line.
- LCLR:
  - Writes {BLANK_ATTR,BLANK_CHAR} to col 0..COLS-1 of the target physical row, one per cycle, wr_en=1 throughout.
  - Returns to IDLE the cycle after the last write. in_ready=0 during LCLR.
- FCLR (entered on clear_req or FF):
  - Writes blank to addresses 0..2047 ascending, one per cycle.
  - On entry, cursor=0/0 and row_base=0.
  - busy=1 from the cycle after the request through the last write.
- clear_req priority:
  - In IDLE, clear_req wins over in_valid; in_ready is low that cycle, so no character is lost.
  - clear_req during LCLR aborts LCLR and starts FCLR the next cycle.
  - clear_req during FCLR restarts FCLR at address 0.
- wr_en is 0 in IDLE on any cycle without a printable write.
- rst_n asserted mid-clear: clear stops immediately and the buffer is left partially cleared.

Optional Feature:
- Macro: CHARBUF_SCROLL_EN.
- Defined (hardware scroll):
  - At bottom-row advance, cursor_row stays ROWS-1 and row_base increments (mod ROWS).
  - LCLR clears physical row (new row_base + ROWS-1) mod ROWS.
  - The renderer adds row_base to its read row.
- Undefined:
  - cursor_row wraps to 0 and LCLR clears physical row 0.
  - row_base is tied to 0; the row_base register and adder are omitted.

Test Plan:
- Reset, then clear_req pulse:
  - busy=1 for 2048 cycles.
  - wr_addr covers 0..2047 ascending, wr_data=16'h0720 on every write.
  - Cursor ends at 0/0; in_ready returns high the cycle after the last write.
- Send 'A' (8'h41) with attr 8'h1E at cursor 0/0:
  - Next cycle: wr_en=1, wr_addr=0, wr_data=16'h1E41.
  - cursor_col=1.
- Line overflow:
  - Place cursor at col 63, row 5 and send 'Z': write at addr 5*64+63=383.
  - Then cursor 0/6 with no LCLR.
- CR, LF, BS handling:
  - CR at col 10 gives col=0 with no wr_en.
  - LF at row 3 gives row 4, col 0.
  - BS at col 0 leaves col 0.
- Bottom LF, scroll disabled:
  - LF at row 31 gives cursor_row=0 and 64 writes at addr 0..63 with 16'h0720.
  - in_ready=0 during those 64 cycles.
- Bottom LF, CHARBUF_SCROLL_EN defined, row_base=0:
  - row_base=1 and cursor_row=31.
  - LCLR writes addr 0..63 (physical row 0).
  - The next 'B' is written at addr 0.
- clear_req and in_valid asserted in the same cycle:
  - in_ready=0, the character is not written, and FCLR starts.
- clear_req at LCLR cycle 20: LCLR aborts and FCLR starts at addr 0 the next cycle.
